// File: rtl/bit_stuff_encoder_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bit_stuff_encoder_if : upstream/downstream bit-stream handshake (rev 1.0)
// ----------------------------------------------------------------------------
interface bit_stuff_encoder_if;
  logic in_valid;
  logic in_bit;
  logic in_last;
  logic in_ready;
  logic out_valid;
  logic out_bit;
  logic out_last;
  logic out_stuffed;
  logic out_ready;

  // master: the traffic source/sink around the encoder; slave: the encoder
  modport master (
    output in_valid, in_bit, in_last, out_ready,
    input  in_ready, out_valid, out_bit, out_last, out_stuffed
  );

  modport slave (
    input  in_valid, in_bit, in_last, out_ready,
    output in_ready, out_valid, out_bit, out_last, out_stuffed
  );
endinterface
`default_nettype wire

// File: rtl/bit_stuff_encoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bit_stuff_encoder : streaming bit stuffer with optional NRZI stage (rev 1.0)
// ----------------------------------------------------------------------------
module bit_stuff_encoder #(
  parameter int unsigned RUN_LEN   = 6,
  parameter int unsigned SKIP_BITS = 8,
  parameter bit          NRZI_EN   = 1'b1
) (
  input wire                 clock,
  input wire                 reset,
  bit_stuff_encoder_if.slave bus
);

  localparam int c_ones_w = $clog2(RUN_LEN + 1);
  localparam int c_bit_w  = (SKIP_BITS > 0) ? $clog2(SKIP_BITS + 1) : 1;
  localparam logic [c_ones_w-1:0] c_run      = c_ones_w'(RUN_LEN);
  localparam logic [c_ones_w-1:0] c_ones_one = c_ones_w'(1);
  localparam logic [c_bit_w-1:0]  c_skip     = c_bit_w'(SKIP_BITS);
  localparam logic [c_bit_w-1:0]  c_bit_one  = c_bit_w'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SKIP  = 2'd1,
    ST_COUNT = 2'd2,
    ST_STUFF = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [c_ones_w-1:0]   ones_cnt_q, ones_cnt_d;
  logic [c_bit_w-1:0]    bit_cnt_q, bit_cnt_d;
  logic                  stuff_pend_q, stuff_pend_d;
  logic                  pend_last_q, pend_last_d;
  logic                  level_q, level_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_bit_q, out_bit_d;
  logic                  out_last_q, out_last_d;
  logic                  out_stuffed_q, out_stuffed_d;

  logic                  w_adv;
  logic                  w_accept;
  logic                  w_load;
  logic                  w_data;
  logic                  w_last;
  logic                  w_stuffed;
  logic                  w_lvl_n;
  logic [c_ones_w-1:0]   w_ones_inc;
  logic [c_bit_w-1:0]    w_bit_inc;

  assign w_adv        = ~out_valid_q | bus.out_ready;
  assign bus.in_ready = w_adv & ~stuff_pend_q;
  assign w_accept     = bus.in_valid & bus.in_ready;
  assign w_ones_inc   = ones_cnt_q + c_ones_one;
  assign w_bit_inc    = bit_cnt_q + c_bit_one;

  always_comb begin
    state_d       = state_q;
    ones_cnt_d    = ones_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    stuff_pend_d  = stuff_pend_q;
    pend_last_d   = pend_last_q;
    level_d       = level_q;
    out_valid_d   = out_valid_q;
    out_bit_d     = out_bit_q;
    out_last_d    = out_last_q;
    out_stuffed_d = out_stuffed_q;
    w_load        = 1'b0;
    w_data        = 1'b0;
    w_last        = 1'b0;
    w_stuffed     = 1'b0;
    w_lvl_n       = level_q;

    if (w_adv) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_STUFF: begin
        if (w_adv) begin
          w_load       = 1'b1;
          w_stuffed    = 1'b1;
          w_last       = pend_last_q;
          ones_cnt_d   = '0;
          stuff_pend_d = 1'b0;
          state_d      = ST_COUNT;
        end
      end
      default: begin
        if (w_accept) begin
          w_load = 1'b1;
          w_data = bus.in_bit;
          w_last = bus.in_last;
          // bit_cnt only reaches c_skip once the header is done, so this
          // also handles IDLE with SKIP_BITS of 0 or 1
          if (bit_cnt_q != c_skip) begin
            bit_cnt_d  = w_bit_inc;
            ones_cnt_d = '0;
            state_d    = (w_bit_inc == c_skip) ? ST_COUNT : ST_SKIP;
          end else begin
            ones_cnt_d = bus.in_bit ? w_ones_inc : '0;
            state_d    = ST_COUNT;
            if (bus.in_bit && (w_ones_inc == c_run)) begin
              stuff_pend_d = 1'b1;
              pend_last_d  = bus.in_last;
              w_last       = 1'b0;
              state_d      = ST_STUFF;
            end
          end
        end
      end
    endcase

    if (w_load) begin
      w_lvl_n       = w_data ? level_q : ~level_q;
      out_valid_d   = 1'b1;
      out_bit_d     = NRZI_EN ? w_lvl_n : w_data;
      out_last_d    = w_last;
      out_stuffed_d = w_stuffed;
      level_d       = w_lvl_n;
      // end of packet: line parks at idle J and no run carries over
      if (w_last) begin
        level_d    = 1'b1;
        ones_cnt_d = '0;
        bit_cnt_d  = '0;
        state_d    = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      ones_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      stuff_pend_q  <= 1'b0;
      pend_last_q   <= 1'b0;
      level_q       <= 1'b1;
      out_valid_q   <= 1'b0;
      out_bit_q     <= 1'b1;
      out_last_q    <= 1'b0;
      out_stuffed_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ones_cnt_q    <= ones_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      stuff_pend_q  <= stuff_pend_d;
      pend_last_q   <= pend_last_d;
      level_q       <= level_d;
      out_valid_q   <= out_valid_d;
      out_bit_q     <= out_bit_d;
      out_last_q    <= out_last_d;
      out_stuffed_q <= out_stuffed_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_bit     = out_bit_q;
  assign bus.out_last    = out_last_q;
  assign bus.out_stuffed = out_stuffed_q;

endmodule
`default_nettype wire

// File: tb/tb_bit_stuff_encoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_bit_stuff_encoder : three encoder configurations, directed and random
// packets, each output beat compared with a packet-level stuffing/NRZI model
// ----------------------------------------------------------------------------
module tb_bit_stuff_encoder;

  // per-instance configuration: {dut2, dut1, dut0}
  localparam logic [23:0] P_RUN  = {8'd3, 8'd6, 8'd6};
  localparam logic [23:0] P_SKIP = {8'd2, 8'd0, 8'd8};
  localparam logic [2:0]  P_NRZI = 3'b010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] in_valid, in_bit, in_last, out_ready;
  wire  [2:0] in_ready_w, o_valid, o_bit, o_last, o_stuffed;

  genvar g;
  for (g = 0; g < 3; g++) begin : g_dut
    bit_stuff_encoder_if bus ();
    assign bus.in_valid   = in_valid[g];
    assign bus.in_bit     = in_bit[g];
    assign bus.in_last    = in_last[g];
    assign bus.out_ready  = out_ready[g];
    assign in_ready_w[g]  = bus.in_ready;
    assign o_valid[g]     = bus.out_valid;
    assign o_bit[g]       = bus.out_bit;
    assign o_last[g]      = bus.out_last;
    assign o_stuffed[g]   = bus.out_stuffed;

    bit_stuff_encoder #(
      .RUN_LEN  (int'(P_RUN[g*8 +: 8])),
      .SKIP_BITS(int'(P_SKIP[g*8 +: 8])),
      .NRZI_EN  (P_NRZI[g])
    ) u_dut (
      .clock(clk),
      .reset(rst),
      .bus  (bus)
    );
  end

  int checks   = 0;
  int failures = 0;

  logic [1:0] in_mem  [3][4096];   // {bit, last}
  logic [2:0] exp_mem [3][4096];   // {bit, last, stuffed}
  int         in_rd[3], in_wr[3], exp_rd[3], exp_wr[3];
  int         stall[3], hold_cnt[3];
  bit         hold_arm[3], hold_fired[3], prev_hold[3];
  logic [2:0] prev_beat[3];
  logic       model_lvl[3];
  logic       pkt[256];
  bit         rand_mode = 1'b0;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("FAIL %s dut=%0d observed=%0h required=%0h", tag, k, obs, req);
    end
  endtask

  task automatic send_str(input int k, input string s, input bit last_end);
    for (int i = 0; i < s.len(); i++) begin
      in_mem[k][in_wr[k]] = {s[i] == "1", last_end && (i == s.len() - 1)};
      in_wr[k]++;
    end
  endtask

  task automatic expect_str(input int k, input string s, input bit last_end);
    for (int i = 0; i < s.len(); i++) begin
      exp_mem[k][exp_wr[k]] = {s[i] == "1", last_end && (i == s.len() - 1), s[i] == "z"};
      exp_wr[k]++;
    end
  endtask

  // emit one line beat: a 0 toggles the NRZI level, a 1 holds it
  task automatic emit(input int k, input logic d, input logic l, input logic s);
    if (!d) model_lvl[k] = ~model_lvl[k];
    exp_mem[k][exp_wr[k]] = {(P_NRZI[k] ? model_lvl[k] : d), l, s};
    exp_wr[k]++;
  endtask

  task automatic model_packet(input int k, input int n);
    int run;
    bit st;
    run = 0;
    model_lvl[k] = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_mem[k][in_wr[k]] = {pkt[i], i == n - 1};
      in_wr[k]++;
      st = 1'b0;
      if (i >= int'(P_SKIP[k*8 +: 8])) begin
        run = pkt[i] ? run + 1 : 0;
        st  = (run == int'(P_RUN[k*8 +: 8]));
      end
      emit(k, pkt[i], (i == n - 1) && !st, 1'b0);
      if (st) begin
        run = 0;
        emit(k, 1'b0, i == n - 1, 1'b1);
      end
    end
  endtask

  task automatic drive(input int k);
    if (hold_arm[k] && o_valid[k] && (exp_rd[k] + 1 < exp_wr[k]) && exp_mem[k][exp_rd[k] + 1][0]) begin
      hold_cnt[k]   = 3;
      hold_arm[k]   = 1'b0;
      hold_fired[k] = 1'b1;
    end
    out_ready[k] = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (hold_cnt[k] > 0) begin
      out_ready[k] = 1'b0;
      hold_cnt[k]--;
    end
    if ((in_rd[k] < in_wr[k]) && (!rand_mode || ($urandom_range(0, 3) != 0))) begin
      in_valid[k] = 1'b1;
      in_bit[k]   = in_mem[k][in_rd[k]][1];
      in_last[k]  = in_mem[k][in_rd[k]][0];
    end else begin
      in_valid[k] = 1'b0;
      in_bit[k]   = 1'($urandom_range(0, 1));
      in_last[k]  = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic observe(input int k);
    logic [2:0] beat;
    beat = {o_bit[k], o_last[k], o_stuffed[k]};
    if (prev_hold[k]) chk("hold_stable", k, {o_valid[k], beat}, {1'b1, prev_beat[k]});
    if (!in_ready_w[k]) stall[k]++;
    if (in_valid[k] && in_ready_w[k]) in_rd[k]++;
    if (o_valid[k] && out_ready[k]) begin
      if (exp_rd[k] < exp_wr[k]) begin
        chk("beat", k, beat, exp_mem[k][exp_rd[k]]);
        exp_rd[k]++;
      end else begin
        chk("extra_beat", k, o_valid[k], 0);
      end
    end
    prev_hold[k] = o_valid[k] && !out_ready[k];
    prev_beat[k] = beat;
  endtask

  task automatic cycle();
    @(negedge clk);
    for (int k = 0; k < 3; k++) drive(k);
    #1;
    for (int k = 0; k < 3; k++) observe(k);
  endtask

  task automatic drain(input int limit);
    int n;
    bit busy;
    n    = 0;
    busy = 1'b1;
    while (busy && (n < limit)) begin
      cycle();
      n++;
      busy = 1'b0;
      for (int k = 0; k < 3; k++)
        if ((in_rd[k] != in_wr[k]) || (exp_rd[k] != exp_wr[k])) busy = 1'b1;
    end
    chk("drain_timeout", 0, busy, 0);
    cycle();
    cycle();
    for (int k = 0; k < 3; k++) chk("idle_after_drain", k, o_valid[k], 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = '1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_rd[k]     = in_wr[k];
      exp_rd[k]    = exp_wr[k];
      prev_hold[k] = 1'b0;
      hold_cnt[k]  = 0;
      stall[k]     = 0;
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_in_ready", k, in_ready_w[k], 1);
      chk("rst_out_valid", k, o_valid[k], 0);
      chk("rst_out_bit", k, o_bit[k], 1);
      chk("rst_out_last", k, o_last[k], 0);
      chk("rst_out_stuffed", k, o_stuffed[k], 0);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      in_rd[k] = 0; in_wr[k] = 0; exp_rd[k] = 0; exp_wr[k] = 0;
      stall[k] = 0; hold_cnt[k] = 0; hold_arm[k] = 0; hold_fired[k] = 0;
      prev_hold[k] = 0; prev_beat[k] = '0; model_lvl[k] = 1'b1;
    end
    in_valid = '0; in_bit = '0; in_last = '0; out_ready = '1;
    repeat (2) @(posedge clk);
    do_reset();

    // run of seven 1s after the PID: one stuff after the sixth
    stall[0] = 0;
    send_str(0, "1111111111111110", 1);
    expect_str(0, "11111111111111z10", 1);
    drain(200);
    chk("t1_ready_low_cycles", 0, stall[0], 1);

    // final bit completes the run: the stuff bit carries last
    stall[0] = 0;
    send_str(0, "00000000111111", 1);
    expect_str(0, "00000000111111z", 1);
    drain(200);
    chk("t2_ready_low_cycles", 0, stall[0], 1);

    // five 1s only: passthrough
    stall[0] = 0;
    send_str(0, "11111111111110", 1);
    expect_str(0, "11111111111110", 1);
    drain(200);
    chk("t3_ready_low_cycles", 0, stall[0], 0);

    // back-pressure for three cycles while the stuff bit is pending
    stall[0] = 0;
    hold_arm[0] = 1'b1;
    hold_fired[0] = 1'b0;
    send_str(0, "1111111111111110", 1);
    expect_str(0, "11111111111111z10", 1);
    drain(200);
    chk("t4_hold_applied", 0, hold_fired[0], 1);
    chk("t4_ready_low_cycles", 0, stall[0], 4);

    // NRZI with no header; second packet restarts from idle J
    send_str(1, "0100", 1);
    expect_str(1, "0010", 1);
    send_str(1, "0100", 1);
    expect_str(1, "0010", 1);
    drain(200);

    // RUN_LEN=3, SKIP_BITS=2: abort mid-packet, next packet starts clean
    send_str(2, "1111", 0);
    expect_str(2, "1111", 0);
    drain(200);
    do_reset();
    send_str(2, "001111", 1);
    expect_str(2, "00111z1", 1);
    drain(200);
    chk("t6_ready_low_cycles", 2, stall[2], 1);

    // random packets, gaps and back-pressure on all three configurations
    rand_mode = 1'b1;
    for (int p = 0; p < 25; p++) begin
      for (int k = 0; k < 3; k++) begin
        int n;
        n = $urandom_range(1, 40);
        for (int i = 0; i < n; i++) pkt[i] = ($urandom_range(0, 4) != 0);
        model_packet(k, n);
      end
    end
    drain(20000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bit_stuff_encoder.md
# bit_stuff_encoder

Parametrised, streaming bit-stuffing encoder with an optional integrated NRZI stage. It sits between the CRC generator and the line driver in the USB transmit path. It generalises the fixed six-ones stuffer in four ways: run length and unstuffed header length are parameters, both sides use a valid/ready handshake with back-pressure, packets are delimited by `in_last`, and a trailing run completed by the final bit still gets its stuff bit.

## Interface
- `RUN_LEN`, default 6: consecutive data 1s that force one inserted stuff 0. Must be ≥1.
- `SKIP_BITS`, default 8: leading bits per packet that are passed through unstuffed and uncounted (PID field). 0 is legal.
- `NRZI_EN`, default 1: 1 = `out_bit` is the NRZI line level; 0 = `out_bit` is the stuffed data bit.
- `clock` in 1: single clock. All registers update on its rising edge.
- `reset` in 1: reset is synchronous and active-high.
- `in_valid` in 1: upstream bit is valid.
- `in_bit` in 1: upstream data bit.
- `in_last` in 1: marks the final bit of the packet.
- `in_ready` out 1: block accepts the upstream bit this cycle.
- `out_valid` out 1: output register holds a beat.
- `out_bit` out 1: output bit (NRZI level or data, per `NRZI_EN`).
- `out_last` out 1: final beat of the packet.
- `out_stuffed` out 1: current beat is an inserted stuff bit.
- `out_ready` in 1: downstream accepts the beat.

## Operation
- Internal state:
  - `ones_cnt`: width clog2(RUN_LEN+1).
  - `bit_cnt`: width clog2(SKIP_BITS+1), saturates at SKIP_BITS.
  - `stuff_pend`, `pend_last`.
  - `level`: NRZI line state.
- `adv = ~out_valid | out_ready`.
- `in_ready = adv & ~stuff_pend`.
- Accept = `in_valid & in_ready`.
- FSM states:
  - IDLE: no packet open, counters 0. Accept → SKIP if SKIP_BITS>1, else COUNT. If the accept carries `in_last`, stay in IDLE.
  - SKIP: `bit_cnt < SKIP_BITS`. Each accept increments `bit_cnt` and holds `ones_cnt`=0. The accept that makes `bit_cnt == SKIP_BITS` → COUNT.
  - COUNT: on accept, `in_bit`=1 increments `ones_cnt` and `in_bit`=0 clears it. If `ones_cnt` reaches RUN_LEN: set `stuff_pend`, set `pend_last=in_last`, load the data beat with `out_last=0`, go to STUFF.
  - STUFF: `in_ready`=0. When `adv`: load data 0 with `out_stuffed`=1 and `out_last=pend_last`, clear `ones_cnt` and `stuff_pend`. Next state is IDLE if `pend_last`, else COUNT.
- Any beat loaded with `out_last`=1 clears `bit_cnt` and `ones_cnt` and returns to IDLE. Bits of the next packet never count toward a previous run.
- With SKIP_BITS=0, the first bit is counted: IDLE accept goes straight to COUNT logic.
- NRZI: on each load, `lvl_n = d ? level : ~level`. `out_bit <= NRZI_EN ? lvl_n : d`, then `level <= lvl_n`. After a beat with `out_last` is loaded, `level <= 1` (idle J).
- When `adv` and nothing is loaded, `out_valid` goes to 0.
- Simultaneous events: a load and an output transfer in the same cycle is full throughput, with no bubble except the STUFF cycle.
- Reset mid-packet: everything returns to reset values and the partial packet is dropped. There is no recovery state.

## Timing
- Reset values:
  - `out_valid`=0, `out_bit`=1, `out_last`=0, `out_stuffed`=0.
  - `in_ready`=1 (after the reset cycle).
  - `level`=1, counters 0, state IDLE.
- Latency: an accepted bit appears on `out_*` the next cycle.
- Throughput: one bit per cycle. Exactly one `in_ready`-low cycle per inserted stuff bit, plus any `out_ready`-low cycles.
- Output beat stability: while `out_valid & ~out_ready`, `out_bit`, `out_last` and `out_stuffed` must not change.
- Stuff placement: the stuff bit always immediately follows the RUN_LEN-th 1, even when back-pressure intervenes.

## Test plan
1. Defaults, NRZI_EN=0. Input 8×1 (PID), then 1,1,1,1,1,1,1,0 with `last` on the 0. Required output: 8×1, 6×1, stuff 0 (`out_stuffed`=1), 1, 0 with `out_last`=1. `in_ready` is low exactly one cycle.
2. Defaults, NRZI_EN=0. Input PID 8×0, then 6×1 with `last` on the sixth 1. Required: 14 data beats, then a stuffed 0 carrying `out_last`=1. The sixth 1 has `out_last`=0.
3. Input PID 8×1, then 5×1, 0 (`last`). Required: no stuff bit; 14 beats out, identical to input.
4. Scenario 1 with `out_ready` held low for 3 cycles while `stuff_pend`=1. Required: output beat held stable, no input accepted, and the sequence is identical to scenario 1.
5. NRZI_EN=1, SKIP_BITS=0. Data 0,1,0,0 (`last`) from reset. Required: `out_bit` 0,0,1,0. The next packet starts from `level`=1.
6. RUN_LEN=3, SKIP_BITS=2. Assert `reset` after 4 accepted 1s. Then send new packet 0,0,1,1,1,1 (`last`). Required: stuff after the third counted 1, i.e. 0,0,1,1,1,0s,1 with `last` on the final 1. No carry-over from the aborted packet.
